bus_arbiter4: RTL and testbench

- Round-robin arbiter that shares one 16-bit data path between four requesters.
- Owns the select lines of the 4-way 16-bit mux and registers one grant at a time.
- Holds the grant while the owner keeps requesting, then rotates fairly to the next requester.
- Sits in front of any single-port shared resource (memory port, output register, bus) in the CPU/memory subsystem.

---
 rtl/bus_arbiter4_pkg.sv | 7 +
 rtl/bus_arbiter4_rr_pick4.sv | 15 +
 rtl/bus_arbiter4.sv | 64 ++++++
 tb/tb_bus_arbiter4.sv | 124 ++++++++++++
 4 files changed

// File: rtl/bus_arbiter4_pkg.sv
// bus_arbiter4_pkg: shared sizes and FSM encoding for the four-requester round-robin arbiter.
package bus_arbiter4_pkg;
    localparam int NUM_REQ   = 4;
    localparam int SEL_W     = 2;
    localparam int DEF_WIDTH = 16;
    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;
endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// rr_pick4: combinational round-robin picker; first set req bit at or after start, wrapping 3->0.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic       found,
    output logic [1:0] idx
);
    logic [3:0] rot;
    assign rot   = 4'({req, req} >> start);
    assign found = |req;
    always_comb begin
        idx = start;
        for (int k = 3; k >= 0; k--) if (rot[k]) idx = start + 2'(k);
    end
endmodule

// File: rtl/bus_arbiter4.sv
// bus_arbiter4: round-robin grant of a shared WIDTH-bit path among four requesters.
// ARB_BURST_LIMIT_EN adds a MAX_BURST cap on consecutive grant cycles when others are waiting.
module bus_arbiter4 import bus_arbiter4_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
`ifdef ARB_BURST_LIMIT_EN
    , parameter int MAX_BURST = 4
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   in0_data,
    input  logic [WIDTH-1:0]   in1_data,
    input  logic [WIDTH-1:0]   in2_data,
    input  logic [WIDTH-1:0]   in3_data,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data
);
    state_t           state;
    logic [SEL_W-1:0] last, idx;
    logic             found, limit, take;

    // The current owner is masked out so a drop or forced release hands over to someone else.
    rr_pick4 u_pick (.req(req & ~gnt), .start(last + 2'd1), .found(found), .idx(idx));

    assign out_valid = (|gnt) & req[sel];
    assign out_data  = !out_valid ? '0 :
                       sel == 2'd0 ? in0_data :
                       sel == 2'd1 ? in1_data :
                       sel == 2'd2 ? in2_data : in3_data;
    assign take = state == IDLE || !out_valid || limit;

`ifdef ARB_BURST_LIMIT_EN
    logic [3:0] cnt;
    assign limit = cnt == 4'(MAX_BURST - 1);
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= (out_valid && !limit) ? cnt + 4'd1 : '0;
    end
`else
    assign limit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            last  <= 2'd3;
        end else if (take) begin
            if (found) begin
                state <= OWN;
                gnt   <= 4'b0001 << idx;
                sel   <= idx;
                last  <= idx;
            end else if (!out_valid) begin
                state <= IDLE;
                gnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: directed stimulus with a queue-based scoreboard checked at each falling edge.
module tb_bus_arbiter4;
    typedef struct {
        int          id;
        logic [3:0]  g;
        int          s;
        logic        v;
        logic [15:0] d;
    } exp_t;

    localparam logic [15:0] D0 = 16'hA000, D1 = 16'hB111, D2 = 16'hBEEF, D3 = 16'hD333;

    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [15:0] in0_data = D0, in1_data = D1, in2_data = D2, in3_data = D3;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        out_valid;
    logic [15:0] out_data;

    exp_t q[$];
    int   n_id = 0, checks = 0, fails = 0;

    bus_arbiter4 dut (
        .clk(clk), .rst(rst), .req(req),
        .in0_data(in0_data), .in1_data(in1_data), .in2_data(in2_data), .in3_data(in3_data),
        .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Inputs change just after a rising edge; the matching expectation is checked at the next falling edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] g, input int s,
                        input logic v, input logic [15:0] d);
        @(posedge clk);
        #1;
        rst = r;
        req = rq;
        q.push_back('{n_id, g, s, v, d});
        n_id++;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (gnt !== e.g || (e.s >= 0 && sel !== 2'(e.s)) || out_valid !== e.v || out_data !== e.d) begin
                    fails++;
                    $display("FAIL step%0d: got gnt=%b sel=%0d valid=%b data=%h, want gnt=%b sel=%0d valid=%b data=%h",
                             e.id, gnt, sel, out_valid, out_data, e.g, e.s, e.v, e.d);
                end
            end
        end
    end

    initial begin
        logic [3:0] g;
        int         wait_cyc;
        repeat (2) @(posedge clk);
        step(1, 4'b0000, 4'b0000, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) step(0, 4'b0000, 4'b0000, 0, 0, 16'h0);
        // All four request; each drops after two grant cycles.
        step(0, 4'b1111, 4'b0000, 0, 0, 16'h0);
        step(0, 4'b1111, 4'b0001, 0, 1, D0);
        step(0, 4'b1111, 4'b0001, 0, 1, D0);
        step(0, 4'b1110, 4'b0001, 0, 0, 16'h0);
        step(0, 4'b1110, 4'b0010, 1, 1, D1);
        step(0, 4'b1110, 4'b0010, 1, 1, D1);
        step(0, 4'b1100, 4'b0010, 1, 0, 16'h0);
        step(0, 4'b1100, 4'b0100, 2, 1, D2);
        step(0, 4'b1100, 4'b0100, 2, 1, D2);
        step(0, 4'b1000, 4'b0100, 2, 0, 16'h0);
        step(0, 4'b1000, 4'b1000, 3, 1, D3);
        step(0, 4'b1000, 4'b1000, 3, 1, D3);
        step(0, 4'b0000, 4'b1000, 3, 0, 16'h0);
        // Owner 2 drops while requester 0 raises in the same cycle.
        step(0, 4'b0100, 4'b0000, -1, 0, 16'h0);
        step(0, 4'b0100, 4'b0100, 2, 1, D2);
        step(0, 4'b0001, 4'b0100, 2, 0, 16'h0);
        step(0, 4'b0001, 4'b0001, 0, 1, D0);
        // Reset while requester 1 owns; pointer returns to 3.
        step(0, 4'b0010, 4'b0001, 0, 0, 16'h0);
        step(0, 4'b0010, 4'b0010, 1, 1, D1);
        step(1, 4'b0010, 4'b0010, 1, 1, D1);
        step(0, 4'b1010, 4'b0000, 0, 0, 16'h0);
        step(0, 4'b1010, 4'b0010, 1, 1, D1);
        step(0, 4'b1000, 4'b0010, 1, 0, 16'h0);
        step(0, 4'b1000, 4'b1000, 3, 1, D3);
        // Requester 0 re-raising does not preempt owner 3.
        step(0, 4'b1001, 4'b1000, 3, 1, D3);
        step(0, 4'b0001, 4'b1000, 3, 0, 16'h0);
        step(0, 4'b0000, 4'b0001, 0, 0, 16'h0);
        step(0, 4'b0000, 4'b0000, -1, 0, 16'h0);
        // A lone requester keeps the grant indefinitely.
        step(0, 4'b0001, 4'b0000, -1, 0, 16'h0);
        for (int i = 0; i < 6; i++) step(0, 4'b0001, 4'b0001, 0, 1, D0);
        step(0, 4'b0000, 4'b0001, 0, 0, 16'h0);
        step(0, 4'b0000, 4'b0000, -1, 0, 16'h0);
        // Two continuous requesters: pointer is 0, so requester 1 wins first.
        step(0, 4'b0011, 4'b0000, -1, 0, 16'h0);
        for (int i = 0; i < 10; i++) begin
`ifdef ARB_BURST_LIMIT_EN
            g = ((i / 4) % 2 == 1) ? 4'b0001 : 4'b0010;
`else
            g = 4'b0010;
`endif
            step(0, 4'b0011, g, g == 4'b0001 ? 0 : 1, 1, g == 4'b0001 ? D0 : D1);
        end
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
